wptr_ctrl: RTL and testbench

Write-side pointer controller for the universal asynchronous FIFO. It runs entirely in the write clock domain and maintains the binary and Gray write pointers. From the read pointer synchronised into the write domain it derives registered full, almost-full and fill-level status. It also produces the write-accept strobe that gates the FIFO memory write port, so it is the writer-side counterpart of the read-pointer logic.

---
 rtl/wptr_ctrl.sv | 83 ++++++++
 tb/tb_wptr_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wptr_ctrl.sv
// Write-side pointer controller for the async FIFO: binary/Gray write pointers plus
// registered full, almost-full and level status. Optional sticky overflow flag: WPTR_OVERFLOW_EN.
module wptr_ctrl #(
  parameter int PTR_WIDTH    = 3,
  parameter int AFULL_THRESH = 3
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 w_en,
  input  logic [PTR_WIDTH-1:0] g_rptr_sync,
  input  logic                 ovf_clr,
  output logic                 w_accept,
  output logic [PTR_WIDTH-1:0] b_wptr,
  output logic [PTR_WIDTH-1:0] g_wptr,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH-1:0] wlevel,
  output logic                 overflow
);

  // The write pointer is "full" when it equals the read pointer with its two top Gray bits flipped.
  localparam logic [PTR_WIDTH-1:0] TOP_MASK  = PTR_WIDTH'(3) << (PTR_WIDTH - 2);
  localparam logic [PTR_WIDTH-1:0] AFULL_LVL = PTR_WIDTH'(AFULL_THRESH);

  logic [PTR_WIDTH-1:0] b_wptr_next;
  logic [PTR_WIDTH-1:0] g_wptr_next;
  logic [PTR_WIDTH-1:0] b_rptr_sync;
  logic [PTR_WIDTH-1:0] level_next;
  logic                 full_next;
  logic                 afull_next;

  assign w_accept = w_en & ~full;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    b_rptr_sync = '0;
    for (int i = 0; i < PTR_WIDTH; i++) begin
      b_rptr_sync[i] = ^(g_rptr_sync >> i);
    end
  end

  always_comb begin
    b_wptr_next = b_wptr + PTR_WIDTH'(w_accept);
    g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next;
    full_next   = (g_wptr_next == (g_rptr_sync ^ TOP_MASK));
    level_next  = b_wptr_next - b_rptr_sync;
    afull_next  = (level_next >= AFULL_LVL);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      b_wptr      <= '0;
      g_wptr      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wlevel      <= '0;
    end else begin
      b_wptr      <= b_wptr_next;
      g_wptr      <= g_wptr_next;
      full        <= full_next;
      almost_full <= afull_next;
      wlevel      <= level_next;
    end
  end

`ifdef WPTR_OVERFLOW_EN
  // A dropped write in the same cycle as a clear keeps the flag set.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      overflow <= 1'b0;
    end else if (w_en && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_ctrl.sv
// Self-checking bench for wptr_ctrl: directed vector table plus a modelled random
// write/read sequence, both checked through an expected-result queue.
module tb_wptr_ctrl;

  localparam int PW = 3;
`ifdef WPTR_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          wclk = 1'b0;
  logic          wrst;
  logic          w_en;
  logic [PW-1:0] g_rptr_sync;
  logic          ovf_clr;
  logic          w_accept;
  logic [PW-1:0] b_wptr;
  logic [PW-1:0] g_wptr;
  logic          full;
  logic          almost_full;
  logic [PW-1:0] wlevel;
  logic          overflow;

  always #5 wclk = ~wclk;

  wptr_ctrl #(.PTR_WIDTH(PW), .AFULL_THRESH(3)) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .w_en        (w_en),
    .g_rptr_sync (g_rptr_sync),
    .ovf_clr     (ovf_clr),
    .w_accept    (w_accept),
    .b_wptr      (b_wptr),
    .g_wptr      (g_wptr),
    .full        (full),
    .almost_full (almost_full),
    .wlevel      (wlevel),
    .overflow    (overflow)
  );

  typedef struct {
    logic [PW-1:0] b;
    logic [PW-1:0] g;
    logic          full;
    logic          af;
    logic [PW-1:0] lvl;
    logic          ovf;
    int            idx;
  } exp_t;

  typedef struct {
    logic          rst;
    logic          wen;
    logic          clr;
    logic [PW-1:0] gr;
    logic          chk_acc;
    logic          acc;
    exp_t          e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[24];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_cmp  = 0;

  function automatic logic [PW-1:0] gray(input int v);
    logic [PW-1:0] x;
    x = v[PW-1:0];
    return x ^ (x >> 1);
  endfunction

  function automatic exp_t mkexp(input int b, input int g, input int f, input int af,
                                 input int lvl, input int ovf, input int idx);
    exp_t e;
    e.b    = b[PW-1:0];
    e.g    = g[PW-1:0];
    e.full = f[0];
    e.af   = af[0];
    e.lvl  = lvl[PW-1:0];
    e.ovf  = ovf[0] & OVF_EN;
    e.idx  = idx;
    return e;
  endfunction

  function automatic vec_t mkvec(input int rst, input int wen, input int clr, input int gr,
                                 input int chk, input int acc, input exp_t e);
    vec_t v;
    v.rst     = rst[0];
    v.wen     = wen[0];
    v.clr     = clr[0];
    v.gr      = gr[PW-1:0];
    v.chk_acc = chk[0];
    v.acc     = acc[0];
    v.e       = e;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv,
                     input int idx);
    n_cmp++;
    if (act !== expv) begin
      n_miss++;
      $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, idx, act, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_miss++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      cmp("b_wptr", 32'(b_wptr), 32'(e.b), e.idx);
      cmp("g_wptr", 32'(g_wptr), 32'(e.g), e.idx);
      cmp("full", 32'(full), 32'(e.full), e.idx);
      cmp("almost_full", 32'(almost_full), 32'(e.af), e.idx);
      cmp("wlevel", 32'(wlevel), 32'(e.lvl), e.idx);
      cmp("overflow", 32'(overflow), 32'(e.ovf), e.idx);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic wen, input logic clr,
                               input logic [PW-1:0] gr, input logic chk_acc,
                               input logic acc, input exp_t e);
    @(negedge wclk);
    wrst        = rst;
    w_en        = wen;
    ovf_clr     = clr;
    g_rptr_sync = gr;
    n_vec++;
    #1;
    if (chk_acc) cmp("w_accept", 32'(w_accept), 32'(acc), e.idx);
    sb.push_back(e);
    @(posedge wclk);
    #1;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b, rb, bn, rbn, lvl, adv;
    logic mfull, movf, wen, acc;
    exp_t e;

    wrst = 1'b1; w_en = 1'b0; ovf_clr = 1'b0; g_rptr_sync = '0;

    //              rst wen clr gr    chk acc        b  g     f af lvl ovf
    vecs[0]  = mkvec(1, 1, 0, 3'b101, 0, 0, mkexp(0, 3'b000, 0, 0, 0, 0, 0));
    vecs[1]  = mkvec(1, 1, 0, 3'b101, 1, 1, mkexp(0, 3'b000, 0, 0, 0, 0, 1));
    vecs[2]  = mkvec(0, 1, 0, 3'b000, 1, 1, mkexp(1, 3'b001, 0, 0, 1, 0, 2));
    vecs[3]  = mkvec(0, 1, 0, 3'b000, 1, 1, mkexp(2, 3'b011, 0, 0, 2, 0, 3));
    vecs[4]  = mkvec(0, 1, 0, 3'b000, 1, 1, mkexp(3, 3'b010, 0, 1, 3, 0, 4));
    vecs[5]  = mkvec(0, 1, 0, 3'b000, 1, 1, mkexp(4, 3'b110, 1, 1, 4, 0, 5));
    vecs[6]  = mkvec(0, 1, 0, 3'b000, 1, 0, mkexp(4, 3'b110, 1, 1, 4, 1, 6));
    vecs[7]  = mkvec(0, 1, 0, 3'b000, 1, 0, mkexp(4, 3'b110, 1, 1, 4, 1, 7));
    vecs[8]  = mkvec(0, 1, 1, 3'b000, 1, 0, mkexp(4, 3'b110, 1, 1, 4, 1, 8));
    vecs[9]  = mkvec(0, 0, 1, 3'b000, 1, 0, mkexp(4, 3'b110, 1, 1, 4, 0, 9));
    vecs[10] = mkvec(0, 0, 0, 3'b001, 1, 0, mkexp(4, 3'b110, 0, 1, 3, 0, 10));
    vecs[11] = mkvec(0, 0, 0, 3'b011, 1, 0, mkexp(4, 3'b110, 0, 0, 2, 0, 11));
    vecs[12] = mkvec(0, 1, 0, 3'b011, 1, 1, mkexp(5, 3'b111, 0, 1, 3, 0, 12));
    vecs[13] = mkvec(0, 1, 0, 3'b011, 1, 1, mkexp(6, 3'b101, 1, 1, 4, 0, 13));
    vecs[14] = mkvec(0, 0, 0, 3'b010, 1, 0, mkexp(6, 3'b101, 0, 1, 3, 0, 14));
    vecs[15] = mkvec(0, 0, 0, 3'b110, 1, 0, mkexp(6, 3'b101, 0, 0, 2, 0, 15));
    vecs[16] = mkvec(0, 1, 0, 3'b110, 1, 1, mkexp(7, 3'b100, 0, 1, 3, 0, 16));
    vecs[17] = mkvec(0, 1, 0, 3'b111, 1, 1, mkexp(0, 3'b000, 0, 1, 3, 0, 17));
    vecs[18] = mkvec(0, 1, 0, 3'b101, 1, 1, mkexp(1, 3'b001, 0, 1, 3, 0, 18));
    vecs[19] = mkvec(0, 1, 0, 3'b101, 1, 1, mkexp(2, 3'b011, 1, 1, 4, 0, 19));
    vecs[20] = mkvec(0, 1, 0, 3'b101, 1, 0, mkexp(2, 3'b011, 1, 1, 4, 1, 20));
    vecs[21] = mkvec(1, 1, 0, 3'b101, 1, 0, mkexp(0, 3'b000, 0, 0, 0, 0, 21));
    vecs[22] = mkvec(0, 1, 0, 3'b000, 1, 1, mkexp(1, 3'b001, 0, 0, 1, 0, 22));
    vecs[23] = mkvec(0, 0, 0, 3'b000, 1, 0, mkexp(1, 3'b001, 0, 0, 1, 0, 23));

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].wen, vecs[i].clr, vecs[i].gr,
                    vecs[i].chk_acc, vecs[i].acc, vecs[i].e);
    end

    // Random traffic against an unwrapped-counter model, with reads never passing writes.
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, mkexp(0, 0, 0, 0, 0, 0, 100));
    b = 0; rb = 0; mfull = 1'b0; movf = 1'b0;
    for (int i = 0; i < 80; i++) begin
      wen = ($urandom_range(0, 3) != 0);
      acc = wen & ~mfull;
      bn  = b + int'(acc);
      adv = $urandom_range(0, (bn - rb) > 2 ? 2 : (bn - rb));
      rbn = rb + adv;
      lvl = bn - rbn;
      movf = movf | (wen & mfull);
      e = mkexp(bn, int'(gray(bn)), int'(lvl == 4), int'(lvl >= 3), lvl, int'(movf), 101 + i);
      applyStimulus(1'b0, wen, 1'b0, gray(rbn), 1'b1, acc, e);
      if (acc) cmp("gray_one_bit", 32'($countones(g_wptr ^ gray(b))), 32'd1, 101 + i);
      b = bn; rb = rbn; mfull = (lvl == 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
